// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit for the execute stage.
// The multiplier is shift-add and the divider is restoring. Both process one
// bit per cycle on operand magnitudes, and the sign is corrected when the
// result is captured. While an operation is in flight the unit requests a
// pipeline stall, and it can be aborted by flush.
// Optional feature macro: MDU_DIV_EN. When defined, the divider and ops
// 100-111 are built. When undefined, those ops complete in one cycle with
// result 0 and an illegal pulse.
module mdu_iter #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [4:0]      rd_in,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out,
   output logic            illegal
);

   localparam int PW = 2 * XLEN;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } stateE;

   // Two's-complement magnitude of v when neg is set.
   function automatic logic [XLEN-1:0] absVal(input logic [XLEN-1:0] v, input logic neg);
      if (neg) begin
         return ~v + XLEN'(1);
      end else begin
         return v;
      end
   endfunction

   stateE            stateR;
   stateE            stateNextS;
   logic             acceptS;
   logic             illegalOpS;
   logic             signAS;
   logic             signBS;
   logic             negS;

   logic [2:0]       opR;
   logic [4:0]       rdR;
   logic [XLEN-1:0]  bMagR;
   logic [XLEN-1:0]  accHiR;
   logic [XLEN-1:0]  accLoR;
   logic [CNT_W-1:0] cntR;
   logic             negR;
   logic             doneR;
   logic             illegalR;
   logic [XLEN-1:0]  resultR;
   logic [4:0]       rdOutR;

   logic [XLEN:0]    mulSumS;
   logic [XLEN-1:0]  hiNextS;
   logic [XLEN-1:0]  loNextS;
   logic [PW-1:0]    prodS;
   logic [PW-1:0]    prodSgnS;
   logic [XLEN-1:0]  finalS;

`ifdef MDU_DIV_EN
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

   logic [XLEN-1:0]  aR;
   logic             divZeroR;
   logic             ovflR;
   logic             divZeroS;
   logic             ovflS;
   logic [XLEN:0]    divShiftS;
   logic [XLEN:0]    divDiffS;
   logic [XLEN-1:0]  quoS;
   logic [XLEN-1:0]  remS;

   assign illegalOpS = 1'b0;
   assign divZeroS   = (b == {XLEN{1'b0}});
   assign ovflS      = ((op == OP_DIV) || (op == OP_REM)) && (a == MOST_NEG) && (b == ALL_ONES);
`else
   assign illegalOpS = op[2];
`endif

   // Reset outranks start, and flush outranks start, when deciding acceptance.
   assign acceptS = (stateR == IDLE) && start && !flush && !rst;

   // Operand signedness and result-negate flag for the incoming op.
   always_comb begin
      signAS = 1'b0;
      signBS = 1'b0;
      negS   = 1'b0;
      case (op)
         OP_MULH, OP_DIV, OP_REM: begin
            signAS = a[XLEN-1];
            signBS = b[XLEN-1];
         end
         OP_MULHSU: signAS = a[XLEN-1];
         default: begin
            signAS = 1'b0;
            signBS = 1'b0;
         end
      endcase
      case (op)
         OP_MULH, OP_DIV:   negS = signAS ^ signBS;
         OP_MULHSU, OP_REM: negS = signAS;
         default:           negS = 1'b0;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         stateR <= IDLE;
      end else begin
         stateR <= stateNextS;
      end
   end

   // Next-state logic. Flush aborts from any state.
   always_comb begin
      stateNextS = stateR;
      case (stateR)
         IDLE: begin
            if (acceptS) begin
               stateNextS = illegalOpS ? DONE : CALC;
            end else begin
               stateNextS = IDLE;
            end
         end
         CALC: begin
            if (flush) begin
               stateNextS = IDLE;
            end else if (cntR == CNT_W'(1)) begin
               stateNextS = DONE;
            end else begin
               stateNextS = CALC;
            end
         end
         DONE:    stateNextS = IDLE;
         default: stateNextS = IDLE;
      endcase
   end

   // FSM outputs. Stall is raised in the start cycle so the pipeline freezes immediately.
   always_comb begin
      stall = 1'b0;
      busy  = 1'b0;
      case (stateR)
         IDLE: begin
            stall = acceptS;
            busy  = 1'b0;
         end
         CALC: begin
            stall = 1'b1;
            busy  = 1'b1;
         end
         DONE: begin
            stall = 1'b0;
            busy  = 1'b1;
         end
         default: begin
            stall = 1'b0;
            busy  = 1'b0;
         end
      endcase
   end

   // One iteration: a shift-add multiply step, or a restoring divide step.
   always_comb begin
      mulSumS = {1'b0, accHiR} + (accLoR[0] ? {1'b0, bMagR} : {(XLEN+1){1'b0}});
      hiNextS = mulSumS[XLEN:1];
      loNextS = {mulSumS[0], accLoR[XLEN-1:1]};
`ifdef MDU_DIV_EN
      divShiftS = {accHiR, accLoR[XLEN-1]};
      divDiffS  = divShiftS - {1'b0, bMagR};
      if (opR[2]) begin
         if (!divDiffS[XLEN]) begin
            hiNextS = divDiffS[XLEN-1:0];
            loNextS = {accLoR[XLEN-2:0], 1'b1};
         end else begin
            hiNextS = divShiftS[XLEN-1:0];
            loNextS = {accLoR[XLEN-2:0], 1'b0};
         end
      end else begin
         hiNextS = mulSumS[XLEN:1];
         loNextS = {mulSumS[0], accLoR[XLEN-1:1]};
      end
`endif
   end

   // Sign correction and special-case selection for the value captured into DONE.
   always_comb begin
      prodS    = {hiNextS, loNextS};
      prodSgnS = negR ? (~prodS + PW'(1)) : prodS;
`ifdef MDU_DIV_EN
      quoS     = negR ? (~loNextS + XLEN'(1)) : loNextS;
      remS     = negR ? (~hiNextS + XLEN'(1)) : hiNextS;
`endif
      finalS   = {XLEN{1'b0}};
      case (opR)
         OP_MUL: finalS = prodSgnS[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: finalS = prodSgnS[PW-1:XLEN];
`ifdef MDU_DIV_EN
         OP_DIV, OP_DIVU: begin
            if (divZeroR) begin
               finalS = ALL_ONES;
            end else if (ovflR) begin
               finalS = aR;
            end else begin
               finalS = quoS;
            end
         end
         OP_REM, OP_REMU: begin
            if (divZeroR) begin
               finalS = aR;
            end else if (ovflR) begin
               finalS = {XLEN{1'b0}};
            end else begin
               finalS = remS;
            end
         end
`endif
         default: finalS = {XLEN{1'b0}};
      endcase
   end

   // Operand capture, iteration registers and registered result/flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         opR      <= 3'b000;
         rdR      <= 5'd0;
         bMagR    <= {XLEN{1'b0}};
         accHiR   <= {XLEN{1'b0}};
         accLoR   <= {XLEN{1'b0}};
         cntR     <= {CNT_W{1'b0}};
         negR     <= 1'b0;
         doneR    <= 1'b0;
         illegalR <= 1'b0;
         resultR  <= {XLEN{1'b0}};
         rdOutR   <= 5'd0;
`ifdef MDU_DIV_EN
         aR       <= {XLEN{1'b0}};
         divZeroR <= 1'b0;
         ovflR    <= 1'b0;
`endif
      end else begin
         doneR    <= 1'b0;
         illegalR <= 1'b0;
         case (stateR)
            IDLE: begin
               if (acceptS) begin
                  opR    <= op;
                  rdR    <= rd_in;
                  accHiR <= {XLEN{1'b0}};
                  accLoR <= absVal(a, signAS);
                  bMagR  <= absVal(b, signBS);
                  negR   <= negS;
                  cntR   <= CNT_W'(XLEN);
`ifdef MDU_DIV_EN
                  aR       <= a;
                  divZeroR <= divZeroS;
                  ovflR    <= ovflS;
`endif
                  if (illegalOpS) begin
                     cntR     <= {CNT_W{1'b0}};
                     doneR    <= 1'b1;
                     illegalR <= 1'b1;
                     resultR  <= {XLEN{1'b0}};
                     rdOutR   <= rd_in;
                  end
               end
            end
            CALC: begin
               if (flush) begin
                  cntR <= {CNT_W{1'b0}};
               end else begin
                  accHiR <= hiNextS;
                  accLoR <= loNextS;
                  cntR   <= cntR - CNT_W'(1);
                  if (cntR == CNT_W'(1)) begin
                     resultR <= finalS;
                     rdOutR  <= rdR;
                     doneR   <= 1'b1;
                  end
               end
            end
            default: begin
               cntR <= cntR;
            end
         endcase
      end
   end

   assign done    = doneR;
   assign illegal = illegalR;
   assign result  = resultR;
   assign rd_out  = rdOutR;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter (XLEN = 32).
// Divider expectations follow the MDU_DIV_EN build selection.
module tb_mdu_iter;

   localparam int XLEN = 32;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [2:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [4:0]      rd_in;
   logic            flush;
   logic            stall;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;
   logic            illegal;

   int testsRun    = 0;
   int testsFailed = 0;
   int doneSeen;

   always #5 clk = ~clk;

   mdu_iter #(.XLEN(XLEN)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
      .rd_in(rd_in), .flush(flush), .stall(stall), .busy(busy),
      .done(done), .result(result), .rd_out(rd_out), .illegal(illegal)
   );

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] expv);
      testsRun++;
      if (got !== expv) begin
         testsFailed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
      end
   endtask

   // Issue one op, measure latency and stall cycles, optionally poke start
   // during CALC (cycle glitchAt) and during DONE, then check the outputs.
   task automatic runOp(input string tag, input logic [2:0] opV, input logic [31:0] aV,
                        input logic [31:0] bV, input logic [4:0] rdV, input logic [31:0] expRes,
                        input int expLat, input logic expIll, input int glitchAt,
                        input logic glitchDone);
      int lat;
      int stallCnt;
      lat      = 0;
      stallCnt = 0;
      @(negedge clk);
      start = 1'b1; op = opV; a = aV; b = bV; rd_in = rdV;
      #1;
      if (stall) stallCnt++;
      checkVal({tag, ".busyAtStart"}, 64'(busy), 64'(1'b0));
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (stall) stallCnt++;
         if (done) begin
            lat = i;
            break;
         end
         if (i == glitchAt) begin
            start = 1'b1; op = OP_MULH; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; rd_in = 5'd31;
         end else begin
            start = 1'b0;
         end
      end
      checkVal({tag, ".latency"}, 64'(lat), 64'(expLat));
      checkVal({tag, ".stallCycles"}, 64'(stallCnt), 64'(expLat));
      checkVal({tag, ".result"}, 64'(result), 64'(expRes));
      checkVal({tag, ".rd"}, 64'(rd_out), 64'(rdV));
      checkVal({tag, ".illegal"}, 64'(illegal), 64'(expIll));
      if (glitchDone) begin
         start = 1'b1; op = OP_MUL; a = 32'd9; b = 32'd9; rd_in = 5'd30;
      end
      @(negedge clk);
      start = 1'b0;
      #1;
      checkVal({tag, ".donePulse"}, 64'(done), 64'(1'b0));
      checkVal({tag, ".illegalPulse"}, 64'(illegal), 64'(1'b0));
      checkVal({tag, ".idleAfter"}, 64'(busy), 64'(1'b0));
      checkVal({tag, ".resultHeld"}, 64'(result), 64'(expRes));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000;
      a = 32'd0; b = 32'd0; rd_in = 5'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkVal("reset.busy", 64'(busy), 64'(1'b0));
      checkVal("reset.stall", 64'(stall), 64'(1'b0));
      checkVal("reset.done", 64'(done), 64'(1'b0));
      checkVal("reset.illegal", 64'(illegal), 64'(1'b0));
      checkVal("reset.result", 64'(result), 64'(32'd0));
      checkVal("reset.rd", 64'(rd_out), 64'(5'd0));
      rst = 1'b0;

      // Multiply family.
      runOp("mul_7xm3",      OP_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33, 1'b0, 0, 1'b0);
      runOp("mulh_minxmin",  OP_MULH,   32'h80000000, 32'h80000000, 5'd1,  32'h40000000, 33, 1'b0, 0, 1'b0);
      runOp("mulhu_maxsq",   OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 33, 1'b0, 0, 1'b0);
      runOp("mulhsu_m1x2",   OP_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd3,  32'hFFFFFFFF, 33, 1'b0, 0, 1'b0);
      runOp("mulhsu_2xmax",  OP_MULHSU, 32'd2,        32'hFFFFFFFF, 5'd4,  32'h00000001, 33, 1'b0, 0, 1'b0);
      runOp("mulh_m1xm1",    OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'h00000000, 33, 1'b0, 0, 1'b0);
      runOp("mulh_m2x3",     OP_MULH,   32'hFFFFFFFE, 32'd3,        5'd8,  32'hFFFFFFFF, 33, 1'b0, 0, 1'b0);
      runOp("mulh_maxpos",   OP_MULH,   32'h7FFFFFFF, 32'h7FFFFFFF, 5'd10, 32'h3FFFFFFF, 33, 1'b0, 0, 1'b0);
      runOp("mulhu_2p33",    OP_MULHU,  32'h80000000, 32'd4,        5'd12, 32'h00000002, 33, 1'b0, 0, 1'b0);
      runOp("mul_wrap",      OP_MUL,    32'h00010000, 32'h00010000, 5'd14, 32'h00000000, 33, 1'b0, 0, 1'b0);

`ifdef MDU_DIV_EN
      runOp("div_m7d2",      OP_DIV,  32'hFFFFFFF9, 32'd2,        5'd15, 32'hFFFFFFFD, 33, 1'b0, 0, 1'b0);
      runOp("rem_m7d2",      OP_REM,  32'hFFFFFFF9, 32'd2,        5'd16, 32'hFFFFFFFF, 33, 1'b0, 0, 1'b0);
      runOp("divu_100d7",    OP_DIVU, 32'd100,      32'd7,        5'd17, 32'd14,       33, 1'b0, 0, 1'b0);
      runOp("remu_100d7",    OP_REMU, 32'd100,      32'd7,        5'd18, 32'd2,        33, 1'b0, 0, 1'b0);
      runOp("div_5d0",       OP_DIV,  32'd5,        32'd0,        5'd19, 32'hFFFFFFFF, 33, 1'b0, 0, 1'b0);
      runOp("remu_5d0",      OP_REMU, 32'd5,        32'd0,        5'd20, 32'd5,        33, 1'b0, 0, 1'b0);
      runOp("div_ovfl",      OP_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd21, 32'h80000000, 33, 1'b0, 0, 1'b0);
      runOp("rem_ovfl",      OP_REM,  32'h80000000, 32'hFFFFFFFF, 5'd22, 32'h00000000, 33, 1'b0, 0, 1'b0);
`else
      runOp("divu_illegal",  OP_DIVU, 32'd10,       32'd3,        5'd15, 32'd0,        1,  1'b1, 0, 1'b0);
      runOp("mul_after_ill", OP_MUL,  32'd3,        32'd4,        5'd16, 32'd12,       33, 1'b0, 0, 1'b0);
      runOp("rem_illegal",   OP_REM,  32'hFFFFFFF9, 32'd2,        5'd17, 32'd0,        1,  1'b1, 0, 1'b0);
`endif

      // start during CALC and during DONE must not disturb the in-flight op.
      runOp("mul_glitch",    OP_MUL,  32'd3,        32'd4,        5'd7,  32'd12,       33, 1'b0, 5, 1'b1);

      // Flush 10 cycles into CALC: back to IDLE, no done, result kept.
      @(negedge clk);
      start = 1'b1; op = OP_MULHU; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; rd_in = 5'd9;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      #1;
      checkVal("flush.idle", 64'(busy), 64'(1'b0));
      doneSeen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) doneSeen++;
      end
      checkVal("flush.noDone", 64'(doneSeen), 64'(0));
      checkVal("flush.resultHeld", 64'(result), 64'(32'd12));
      checkVal("flush.rdHeld", 64'(rd_out), 64'(5'd7));

      // start together with flush in IDLE is not accepted.
      @(negedge clk);
      start = 1'b1; flush = 1'b1; op = OP_MUL; a = 32'd2; b = 32'd2; rd_in = 5'd1;
      #1;
      checkVal("startFlush.stall", 64'(stall), 64'(1'b0));
      @(posedge clk);
      #1;
      start = 1'b0; flush = 1'b0;
      @(negedge clk);
      checkVal("startFlush.busy", 64'(busy), 64'(1'b0));
      doneSeen = 0;
      repeat (40) begin
         @(negedge clk);
         if (done) doneSeen++;
      end
      checkVal("startFlush.noDone", 64'(doneSeen), 64'(0));
      checkVal("startFlush.resultHeld", 64'(result), 64'(32'd12));

      runOp("mul_afterFlush", OP_MUL, 32'd5, 32'd6, 5'd11, 32'd30, 33, 1'b0, 0, 1'b0);

      // Reset in the middle of CALC clears everything on the next edge.
      @(negedge clk);
      start = 1'b1; op = OP_MUL; a = 32'd7; b = 32'd7; rd_in = 5'd12;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checkVal("rstMid.busy", 64'(busy), 64'(1'b0));
      checkVal("rstMid.stall", 64'(stall), 64'(1'b0));
      checkVal("rstMid.done", 64'(done), 64'(1'b0));
      checkVal("rstMid.illegal", 64'(illegal), 64'(1'b0));
      checkVal("rstMid.result", 64'(result), 64'(32'd0));
      checkVal("rstMid.rd", 64'(rd_out), 64'(5'd0));
      rst = 1'b0;

      runOp("mul_afterRst", OP_MUL, 32'd2, 32'd3, 5'd13, 32'd6, 33, 1'b0, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
